// File: rtl/adder_serial_if.sv
// rtl/adder_serial_if.sv - operand/result bundle for adder_serial; sub port only with ADDER_SERIAL_SUB_EN
interface adder_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             cin;
`ifdef ADDER_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

`ifdef ADDER_SERIAL_SUB_EN
  modport master (output start, dataa, datab, cin, sub,
                  input  busy, done, sum, cout, overflow);
  modport slave  (input  start, dataa, datab, cin, sub,
                  output busy, done, sum, cout, overflow);
`else
  modport master (output start, dataa, datab, cin,
                  input  busy, done, sum, cout, overflow);
  modport slave  (input  start, dataa, datab, cin,
                  output busy, done, sum, cout, overflow);
`endif
endinterface

// File: rtl/adder_serial.sv
// rtl/adder_serial.sv - digit-serial adder, CHUNK bits per cycle; ADDER_SERIAL_SUB_EN enables subtract
module adder_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  adder_serial_if.slave io_bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  // Operands shift right one chunk per cycle so the adder always sees bits [CHUNK-1:0].
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_carry;
  logic [K_W-1:0]   r_k;
  logic [WIDTH-1:0] r_partial;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;

  logic [WIDTH-1:0]       w_b_eff;
  logic                   w_c_init;
  logic [CHUNK-1:0]       w_p;
  logic                   w_c_out;
  logic [CHUNK+WIDTH-1:0] w_cat;
  logic [WIDTH-1:0]       w_partial_next;

  // Effective B and initial carry: subtract is A + ~B + 1.
`ifdef ADDER_SERIAL_SUB_EN
  assign w_b_eff  = io_bus.sub ? ~io_bus.datab : io_bus.datab;
  assign w_c_init = io_bus.sub ? 1'b1 : io_bus.cin;
`else
  assign w_b_eff  = io_bus.datab;
  assign w_c_init = io_bus.cin;
`endif

  assign {w_c_out, w_p} = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};

  // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at the LSB.
  assign w_cat          = {w_p, r_partial} >> CHUNK;
  assign w_partial_next = w_cat[WIDTH-1:0];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next state; DONE accepts start exactly like IDLE for back-to-back operation.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (io_bus.start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_k == K_LAST) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, one chunk per RUN cycle, publish results on the last chunk.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_carry    <= 1'b0;
      r_k        <= '0;
      r_partial  <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_a     <= io_bus.dataa;
      r_b     <= w_b_eff;
      r_a_msb <= io_bus.dataa[WIDTH-1];
      r_b_msb <= w_b_eff[WIDTH-1];
      r_carry <= w_c_init;
      r_k     <= '0;
    end else if (r_state == S_RUN) begin
      r_a       <= r_a >> CHUNK;
      r_b       <= r_b >> CHUNK;
      r_carry   <= w_c_out;
      r_k       <= r_k + K_W'(1);
      r_partial <= w_partial_next;
      if (w_last) begin
        r_sum      <= w_partial_next;
        r_cout     <= w_c_out;
        r_overflow <= (r_a_msb == r_b_msb) && (w_partial_next[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign io_bus.busy     = (r_state == S_RUN);
  assign io_bus.done     = (r_state == S_DONE);
  assign io_bus.sum      = r_sum;
  assign io_bus.cout     = r_cout;
  assign io_bus.overflow = r_overflow;

endmodule

// File: tb/tb_adder_serial.sv
// tb/tb_adder_serial.sv - scoreboard bench for adder_serial (WIDTH=16, CHUNK=4)
module tb_adder_serial;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_serial_if #(.WIDTH(WIDTH)) u_if ();

  adder_serial #(.WIDTH(WIDTH), .CHUNK(4)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (u_if.slave)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] held_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    logic [15:0] be;
    logic        ci;
    logic [16:0] f;
    exp_t        e;
    be    = s ? ~b : b;
    ci    = s ? 1'b1 : c;
    f     = {1'b0, a} + {1'b0, be} + {16'd0, ci};
    e.sum  = f[15:0];
    e.cout = f[16];
    e.ovf  = (a[15] == be[15]) && (f[15] != a[15]);
    return e;
  endfunction

  task automatic drive(input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    u_if.start = st;
    u_if.dataa = a;
    u_if.datab = b;
    u_if.cin   = c;
`ifdef ADDER_SERIAL_SUB_EN
    u_if.sub   = s;
`else
    if (s) u_if.cin = c;
`endif
  endtask

  // Called at a negedge; drives start there and returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input exp_t e, input int ign_at);
    int   busy_cnt;
    logic got;
    exp_t q;
    busy_cnt = 0;
    got      = 1'b0;
    drive(1'b1, a, b, c, s);
    sb.push_back(e);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      u_if.start = 1'b0;
      if (u_if.done) begin
        got = 1'b1;
        check({tag, "_busy_in_done"}, {31'd0, u_if.busy}, 32'd0);
        check({tag, "_latency"}, busy_cnt, 32'd4);
        check({tag, "_sb_nonempty"}, sb.size(), 32'd1);
        if (sb.size() > 0) begin
          q = sb.pop_front();
          check({tag, "_sum"},  {16'd0, u_if.sum},      {16'd0, q.sum});
          check({tag, "_cout"}, {31'd0, u_if.cout},     {31'd0, q.cout});
          check({tag, "_ovf"},  {31'd0, u_if.overflow}, {31'd0, q.ovf});
          held_sum = q.sum;
        end
      end else begin
        if (u_if.busy) busy_cnt++;
        check({tag, "_sum_held"}, {16'd0, u_if.sum}, {16'd0, held_sum});
        if (ign_at != 0 && busy_cnt == ign_at) drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      end
    end
    check({tag, "_timeout"}, {31'd0, got}, 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        saw_done;

    held_sum = 16'h0000;
    reset    = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, u_if.busy},     32'd0);
    check("rst_done", {31'd0, u_if.done},     32'd0);
    check("rst_sum",  {16'd0, u_if.sum},      32'd0);
    check("rst_cout", {31'd0, u_if.cout},     32'd0);
    check("rst_ovf",  {31'd0, u_if.overflow}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", {31'd0, u_if.busy}, 32'd0);
    check("idle_done", {31'd0, u_if.done}, 32'd0);
    check("idle_sum",  {16'd0, u_if.sum},  32'd0);

    // Basic add with an ignored start during busy cycle 2.
    run_op("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}, 2);
    @(negedge clk);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}, 0);
    // Back-to-back: started in the done cycle of the previous op.
    run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}, 0);
    run_op("cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, '{16'h0100, 1'b0, 1'b0}, 0);
    run_op("negneg", 16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}, 0);

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      run_op("rand", ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0), 0);
    end

`ifdef ADDER_SERIAL_SUB_EN
    @(negedge clk);
    run_op("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}, 0);
    run_op("sub8000", 16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}, 0);
    ra = 16'($urandom);
    rb = 16'($urandom);
    run_op("subrand", ra, rb, 1'b0, 1'b1, model(ra, rb, 1'b0, 1'b1), 0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
`endif

    // Reset at busy cycle 2 aborts the operation.
    @(negedge clk);
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    u_if.start = 1'b0;
    check("abort_busy_pre", {31'd0, u_if.busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, u_if.busy}, 32'd0);
    check("abort_done", {31'd0, u_if.done}, 32'd0);
    check("abort_sum",  {16'd0, u_if.sum},  32'd0);
    check("abort_cout", {31'd0, u_if.cout}, 32'd0);
    held_sum = 16'h0000;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (u_if.done || u_if.busy) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    // Reset and start on the same edge: start dropped.
    drive(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    u_if.start = 1'b0;
    saw_done   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (u_if.done || u_if.busy) saw_done = 1'b1;
    end
    check("rst_start_dropped", {31'd0, saw_done}, 32'd0);

    run_op("after_rst", 16'h0001, 16'h0001, 1'b1, 1'b0, '{16'h0003, 1'b0, 1'b0}, 0);
    @(negedge clk);
    check("sum_hold_idle", {16'd0, u_if.sum}, 32'h0003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
